// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
// State encoding, response bytes and word geometry helper.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CNT,
    GET_DATA,
    GET_SUM,
    RESPOND
  } state_t;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/uart_loader_timer.sv
// Inactivity counter for the UART loader.
// Flags tc once TIMEOUT enabled cycles pass without a clear.
module uart_loader_timer #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign tc = en && (cnt == CW'(TIMEOUT - 1));

  // count enabled cycles, saturating at the terminal value
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_word_loader.sv
// Framed UART program loader: SYNC, N, N words, checksum.
// Writes words to instruction memory and answers ACK/NAK.
module uart_word_loader
  import uart_loader_pkg::*;
#(
  parameter int         DATA_W    = 16,
  parameter int         ADDR_W    = 8,
  parameter int         TIMEOUT   = 1_000_000,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_empty,
  input  logic [7:0]        r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic [7:0]        w_data,
  output logic              wr_uart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BPW = bytes_per_word(DATA_W);
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BIW-1:0] LAST_IDX = BIW'(BPW - 1);

  state_t state, state_n;

  logic              take;
  logic              tmr_clr;
  logic              tmr_en;
  logic              tmr_tc;

  logic [DATA_W+7:0] shifted;
  logic [DATA_W-1:0] word, word_n;
  logic [7:0]        sum, sum_n;
  logic [7:0]        sum_add;
  logic [7:0]        left, left_n;
  logic [7:0]        resp, resp_n;
  logic [BIW-1:0]    bidx, bidx_n;
  logic [ADDR_W-1:0] waddr, waddr_n;

  logic              rd_n;
  logic              we_n;
  logic [ADDR_W-1:0] maddr_n;
  logic [DATA_W-1:0] mwdata_n;
  logic              wr_n;
  logic [7:0]        wdat_n;
  logic              done_n;
  logic              err_n;

  assign tmr_en  = (state == GET_CNT) ||
                   (state == GET_DATA) ||
                   (state == GET_SUM);
  assign tmr_clr = take || (state_n != state);

  // little-endian assembly: new byte enters at the top
  assign shifted = {r_data, word} >> 8;
  assign sum_add = sum + r_data;

  uart_loader_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .tc     (tmr_tc)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next-state, datapath and registered-output next values
  always_comb begin
    state_n  = state;
    word_n   = word;
    sum_n    = sum;
    left_n   = left;
    resp_n   = resp;
    bidx_n   = bidx;
    waddr_n  = waddr;
    we_n     = 1'b0;
    maddr_n  = mem_addr;
    mwdata_n = mem_wdata;
    wr_n     = 1'b0;
    wdat_n   = w_data;
    done_n   = 1'b0;
    err_n    = err;

    // a pop is in flight while rd_uart is high
    take = !rx_empty && !rd_uart && (state != RESPOND);
    rd_n = take;

    unique case (state)
      IDLE: begin
        if (take && (r_data == SYNC_BYTE)) begin
          state_n = GET_CNT;
          err_n   = 1'b0;
        end
      end
      GET_CNT: begin
        if (take) begin
          if (r_data == 8'd0) begin
            resp_n  = NAK;
            state_n = RESPOND;
          end else begin
            left_n  = r_data;
            waddr_n = '0;
            sum_n   = 8'd0;
            bidx_n  = '0;
            state_n = GET_DATA;
          end
        end else if (tmr_tc) begin
          resp_n  = NAK;
          state_n = RESPOND;
        end
      end
      GET_DATA: begin
        if (take) begin
          word_n = shifted[DATA_W-1:0];
          sum_n  = sum_add;
          if (bidx == LAST_IDX) begin
            bidx_n   = '0;
            we_n     = 1'b1;
            maddr_n  = waddr;
            mwdata_n = shifted[DATA_W-1:0];
            waddr_n  = waddr + 1'b1;
            left_n   = left - 8'd1;
            if (left == 8'd1) begin
              state_n = GET_SUM;
            end
          end else begin
            bidx_n = bidx + 1'b1;
          end
        end else if (tmr_tc) begin
          resp_n  = NAK;
          state_n = RESPOND;
        end
      end
      GET_SUM: begin
        if (take) begin
          resp_n  = (r_data == sum) ? ACK : NAK;
          state_n = RESPOND;
        end else if (tmr_tc) begin
          resp_n  = NAK;
          state_n = RESPOND;
        end
      end
      RESPOND: begin
        if (!tx_full) begin
          wr_n    = 1'b1;
          wdat_n  = resp;
          done_n  = (resp == ACK);
          err_n   = (resp == ACK) ? err : 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // frame datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word  <= '0;
      sum   <= 8'd0;
      left  <= 8'd0;
      resp  <= 8'd0;
      bidx  <= '0;
      waddr <= '0;
    end else begin
      word  <= word_n;
      sum   <= sum_n;
      left  <= left_n;
      resp  <= resp_n;
      bidx  <= bidx_n;
      waddr <= waddr_n;
    end
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_uart   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_uart   <= 1'b0;
      w_data    <= 8'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rd_uart   <= rd_n;
      mem_we    <= we_n;
      mem_addr  <= maddr_n;
      mem_wdata <= mwdata_n;
      wr_uart   <= wr_n;
      w_data    <= wdat_n;
      done      <= done_n;
      err       <= err_n;
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_word_loader.sv
// Scoreboard bench for uart_word_loader (DATA_W=16, TIMEOUT=100).
// Stimulus queues expected writes/responses; a monitor checks them.
module tb_uart_word_loader;
  import uart_loader_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rx_empty;
  logic [7:0]    r_data;
  logic          rd_uart;
  logic          tx_full;
  logic [7:0]    w_data;
  logic          wr_uart;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic          err;

  logic [7:0] fifo [256];
  int head = 0;
  int tail = 0;
  int cyc = 0;

  logic [7:0]       exp_tx [$];
  logic [AW+DW-1:0] exp_mem [$];

  int checks = 0;
  int passed = 0;
  int last_rd_cyc = 0;
  int last_wr_cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int we_cnt = 0;

  always #5 clk = ~clk;

  assign rx_empty = (head == tail);
  assign r_data   = fifo[head[7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_uart && (head != tail)) head <= head + 1;
  end

  uart_word_loader #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .TIMEOUT  (TO),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .tx_full  (tx_full),
    .w_data   (w_data),
    .wr_uart  (wr_uart),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic push(input logic [7:0] b);
    fifo[tail[7:0]] = b;
    tail++;
  endtask

  task automatic monitor();
    logic [7:0]       e;
    logic [AW+DW-1:0] m;
    forever begin
      @(negedge clk);
      if (rd_uart) last_rd_cyc = cyc;
      if (mem_we) begin
        we_cnt++;
        if (exp_mem.size() == 0) begin
          chk("unexpected_write", {mem_addr, mem_wdata}, 0);
        end else begin
          m = exp_mem.pop_front();
          chk("mem_write", {mem_addr, mem_wdata}, m);
        end
      end
      if (wr_uart) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (exp_tx.size() == 0) begin
          chk("unexpected_tx", w_data, 8'hFF);
        end else begin
          e = exp_tx.pop_front();
          chk("tx_byte", w_data, e);
          chk("done_with_tx", done, e == ACK);
          chk("err_with_tx", err, e == NAK);
        end
      end
      if (done) done_cnt++;
      if (done && !wr_uart) chk("done_without_tx", 1, 0);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(head == tail && !busy && !rd_uart &&
             exp_tx.size() == 0 && exp_mem.size() == 0) &&
           n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk({name, "_idle_timeout"}, n, 0);
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    while (head != tail && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("drain_timeout", n, 0);
  endtask

  function automatic logic [63:0] outs();
    return {rd_uart, wr_uart, w_data, mem_we, mem_addr,
            mem_wdata, busy, done, err};
  endfunction

  initial begin
    fork
      monitor();
    join_none

    reset_n = 1'b0;
    tx_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // basic frame: two words, good checksum
    exp_mem.push_back({8'd0, 16'h1234});
    exp_mem.push_back({8'd1, 16'h5678});
    exp_tx.push_back(ACK);
    push(8'hA5); push(8'h02); push(8'h34); push(8'h12);
    push(8'h78); push(8'h56); push(8'h14);
    wait_idle("ack", 200);
    chk("ack_latency", last_wr_cyc - last_rd_cyc, 1);
    chk("ack_done_count", done_cnt, 1);
    chk("ack_err", err, 0);
    chk("ack_writes", we_cnt, 2);

    // same frame, bad checksum: writes stay, NAK
    exp_mem.push_back({8'd0, 16'h1234});
    exp_mem.push_back({8'd1, 16'h5678});
    exp_tx.push_back(NAK);
    push(8'hA5); push(8'h02); push(8'h34); push(8'h12);
    push(8'h78); push(8'h56); push(8'h15);
    wait_idle("nak", 200);
    repeat (20) @(negedge clk);
    chk("nak_err_held", err, 1);
    chk("nak_done_count", done_cnt, 1);

    // garbage is swallowed silently, err persists
    push(8'h00); push(8'hFF); push(8'h3C);
    wait_idle("garbage", 100);
    repeat (5) @(negedge clk);
    chk("garbage_err_held", err, 1);
    chk("garbage_no_tx", wr_cnt, 2);
    exp_mem.push_back({8'd0, 16'hABCD});
    exp_tx.push_back(ACK);
    push(8'hA5); push(8'h01); push(8'hCD); push(8'hAB);
    push(8'h78);
    wait_idle("after_garbage", 200);
    chk("after_garbage_err", err, 0);

    // timeout: half a word, then silence
    exp_tx.push_back(NAK);
    push(8'hA5); push(8'h01); push(8'h34);
    wait_drained(50);
    repeat (50) @(negedge clk);
    chk("timeout_busy_mid", busy, 1);
    wait_idle("timeout", 300);
    chk("timeout_latency", last_wr_cyc - last_rd_cyc, TO + 1);
    chk("timeout_no_write", we_cnt, 5);
    chk("timeout_busy_after", busy, 0);

    // tx_full backpressure at frame end
    tx_full = 1'b1;
    exp_mem.push_back({8'd0, 16'hBEEF});
    exp_tx.push_back(ACK);
    push(8'hA5); push(8'h01); push(8'hEF); push(8'hBE);
    push(8'hAD);
    wait_drained(50);
    begin
      int wr_before;
      int drop_cyc;
      wr_before = wr_cnt;
      repeat (50) @(negedge clk);
      chk("txfull_hold", wr_cnt, wr_before);
      chk("txfull_busy", busy, 1);
      tx_full = 1'b0;
      drop_cyc = cyc;
      wait_idle("txfull", 50);
      chk("txfull_release", last_wr_cyc, drop_cyc + 1);
    end

    // zero word count: immediate NAK
    exp_tx.push_back(NAK);
    push(8'hA5); push(8'h00);
    wait_idle("zero_cnt", 50);
    chk("zero_cnt_latency", last_wr_cyc - last_rd_cyc, 1);
    chk("zero_cnt_err", err, 1);

    // reset mid-frame after second data byte
    exp_mem.push_back({8'd0, 16'h2211});
    push(8'hA5); push(8'h02); push(8'h11); push(8'h22);
    wait_drained(50);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midframe_reset_outputs", outs(), 0);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("midframe_no_tx", wr_cnt, 6);
    chk("midframe_idle", busy, 0);
    exp_mem.push_back({8'd0, 16'h3344});
    exp_tx.push_back(ACK);
    push(8'hA5); push(8'h01); push(8'h44); push(8'h33);
    push(8'h77);
    wait_idle("post_reset", 200);
    chk("post_reset_err", err, 0);

    chk("total_done", done_cnt, 4);
    chk("total_tx", wr_cnt, 7);
    chk("total_writes", we_cnt, 8);
    chk("sb_tx_empty", exp_tx.size(), 0);
    chk("sb_mem_empty", exp_mem.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_word_loader.md
# uart_word_loader

Parametrised UART program loader for the single-stage core. Replaces the manual button-driven byte path with a framed protocol. Consumes bytes from the existing `uart` driver's receive FIFO, assembles them into DATA_W-bit words and writes them sequentially into instruction memory. Verifies an 8-bit checksum and answers ACK/NAK over the UART transmitter, with an inactivity timeout that aborts stalled frames.

## Interface
- DATA_W, 16, memory word width; a multiple of 8, minimum 8
- ADDR_W, 8, memory address width
- TIMEOUT, 1_000_000, idle clock cycles allowed between bytes inside a frame
- SYNC_BYTE, 8'hA5, frame start marker
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- rx_empty  in  1  UART receive FIFO empty
- r_data  in  8  UART receive FIFO head byte
- rd_uart  out  1  one-cycle pop of the receive FIFO
- tx_full  in  1  UART transmit FIFO full
- w_data  out  8  response byte to the transmitter
- wr_uart  out  1  one-cycle push to the transmit FIFO
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory write address
- mem_wdata  out  DATA_W  memory write data
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse on ACK
- err  out  1  high from NAK until the next accepted SYNC_BYTE

## Operation
- Frame format: SYNC_BYTE, N (word count, 1..255), N×(DATA_W/8) data bytes, checksum byte.
- Checksum: 8-bit sum, modulo 256, of all data bytes only.
- Byte order within a word is little-endian: the first data byte maps to bits [7:0].
- States: IDLE, GET_CNT, GET_DATA, GET_SUM, RESPOND.
- IDLE: every byte is popped.
  - SYNC_BYTE moves to GET_CNT and clears err.
  - Any other byte is discarded.
- GET_CNT:
  - N=0 moves to RESPOND with NAK.
  - Otherwise latch N, set the address counter to 0, clear the checksum, and move to GET_DATA.
- GET_DATA:
  - Shift each byte into the word register and add it to the checksum.
  - When the word's last byte arrives, write the word and increment the address.
  - The address wraps modulo 2^ADDR_W.
  - After word N, move to GET_SUM.
- GET_SUM: a match moves to RESPOND with ACK (8'h06); a mismatch moves to RESPOND with NAK (8'h15).
- Memory writes are not rolled back on NAK. The host resends the frame.
- RESPOND:
  - Wait while tx_full=1.
  - When tx_full=0, pulse wr_uart with w_data set to the response.
  - For ACK, also pulse done; for NAK, set err.
  - Then return to IDLE.
- Timeout:
  - Active in GET_CNT, GET_DATA and GET_SUM.
  - The counter clears on every captured byte and on state entry.
  - At TIMEOUT cycles without a byte, go to RESPOND with NAK.
  - Bytes arriving while in RESPOND stay in the FIFO until IDLE.

## Timing
- All outputs are registered.
- In the cycle after any clk edge with reset_n=0, every output is 0 and state is IDLE. This holds even mid-frame; a partial frame is dropped with no response.
- Byte read:
  - In cycle t, rx_empty=0 with no read pending: capture r_data.
  - rd_uart=1 in cycle t+1.
  - rx_empty is ignored in t+1.
  - Peak rate: one byte per 2 cycles.
- mem_we is high for one cycle, the cycle after the final byte of a word is captured. mem_addr and mem_wdata are valid in that cycle and held until the next write.
- wr_uart and done are high in the same single cycle, the first RESPOND cycle with tx_full=0.
- The next IDLE cycle follows immediately.
- Frame latency: response pushed at most 3 cycles after the checksum byte is visible, provided tx_full=0.

## Structure
- Package `uart_loader_pkg`: state enum, ACK/NAK constants, and a BYTES_PER_WORD function (DATA_W/8).
- One sub-module, `uart_loader_timer`: a cycle counter with clear and enable inputs and a terminal-count flag at TIMEOUT.
- Byte shifting, checksum and address counting stay in the top level.

## Test plan
- DATA_W=16, send A5 02 34 12 78 56 14:
  - mem[0]=16'h1234, then mem[1]=16'h5678.
  - ACK 06 pushed, done pulses once, err=0.
- Same frame with checksum 15: both writes occur, then NAK 15 is pushed, err=1 and stays high until the next A5.
- Garbage 00 FF 3C before a valid frame: no writes, no response to the garbage, then the normal ACK for the frame.
- TIMEOUT=100, send A5 01 34 then stop:
  - NAK pushed 100 cycles after the last byte is captured.
  - No mem_we, busy falls after the push.
- tx_full held high for 50 cycles at a valid frame's end: wr_uart stays 0, then pulses the cycle after tx_full drops. Also verify A5 00 gives an immediate NAK.
- Assert reset_n=0 for 1 cycle after the second data byte: outputs become 0, state is IDLE, no response. A subsequent full frame is ACKed and written from address 0.
